scrambler_xor_stage: RTL and testbench
======================================

# scrambler_xor_stage

Downstream consumer of the 195-bit primary LFSR state. Accepts a framed stream of 32-bit data words and XORs each accepted word with a 32-bit slice of the LFSR state. It pulses the LFSR `enable` once per accepted word, so the keystream advances exactly one LFSR step-group per word. It presents scrambled words through a 2-entry output buffer with valid/ready flow control, and flags seed writes made to the LFSR while a frame is in flight.

## Interface
Parameters:
- `POLY_WIDTH`, 195, width of the LFSR state input.
- `DATA_WIDTH`, 32, data word width; `KEY_LSB + DATA_WIDTH <= POLY_WIDTH`.
- `KEY_LSB`, 0, low bit index of the keystream slice taken from `lfsr_state`.
- `LEN_WIDTH`, 16, width of the frame length.

Ports:
- `clk` in 1: single clock; all logic rises on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse that arms one frame; honoured only in IDLE.
- `frame_len` in LEN_WIDTH: words in the frame, sampled on `start`. A value of 0 is treated as 1.
- `write` in 1: register bus write strobe, snooped.
- `addr` in 12: register bus address, snooped.
- `lfsr_state` in POLY_WIDTH: current LFSR register value (`dout` of the LFSR).
- `lfsr_enable` out 1: advance request to the LFSR (its `enable`).
- `in_valid` in 1, `in_ready` out 1, `in_data` in DATA_WIDTH: input stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_WIDTH: scrambled stream.
- `out_last` out 1: qualifies the final word of the frame.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: one-cycle pulse at frame completion.
- `seed_err` out 1: sticky; cleared only by `rst` or `start`.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on `start`.
  - Loads `remaining <= max(frame_len, 1)`.
  - Clears `seed_err`.
- RUN:
  - `in_ready = (buf_count < 2)`.
  - Accept = `in_valid & in_ready`.
  - On accept:
    - Pushes `in_data ^ lfsr_state[KEY_LSB +: DATA_WIDTH]`, tagged last when `remaining == 1`.
    - Drives `lfsr_enable = 1` combinationally in that same cycle.
    - Decrements `remaining`.
  - Accept with `remaining == 1` → DRAIN.
- DRAIN:
  - `in_ready = 0`.
  - When the buffer empties (pop of last entry) → IDLE, with `done` pulsed that cycle.
- `lfsr_enable = accept`, exactly. It is never asserted in IDLE or DRAIN.
- Output buffer is a 2-entry FIFO.
  - Head is on `out_data` and `out_last`.
  - `out_valid = (buf_count != 0)`.
  - Pop on `out_valid & out_ready`.
  - Simultaneous push and pop keeps the count unchanged and preserves order.
- Seed guard: `write` with `addr` in 0x0E8..0x0EE while `busy` sets `seed_err`. The write is not blocked.
- `start` while busy is ignored. `frame_len` is not re-sampled.
- `rst` mid-frame:
  - FSM → IDLE, buffer flushed, `remaining` = 0.
  - `lfsr_enable` drops in the same cycle `rst` is sampled.
  - LFSR state is not touched by this block.

## Timing
- Reset values are all 0: `lfsr_enable`, `in_ready`, `out_valid`, `out_data`, `out_last`, `busy`, `done`, `seed_err`.
- Keystream alignment:
  - The word accepted at cycle t uses `lfsr_state` at t.
  - The LFSR presents the advanced state at t+1, so back-to-back accepts use consecutive step-groups.
- Latency: a word accepted at t is visible on `out_data`/`out_valid` at t+1 when the buffer was empty.
- Throughput: 1 word/cycle with `out_ready` held high.
- With `out_ready` low, two words are accepted, then `in_ready` deasserts at the cycle after the second push.
- `in_ready` depends only on registered state, never on `in_valid`.
- `done` asserts in the cycle the last word is popped. `busy` is low from the next cycle.

## Configuration
- `SCRAMBLER_BYPASS_EN` defined:
  - Adds input port `bypass` (1 bit), sampled on `start` and held for the frame.
  - When the held bypass is 1, words pass unmodified and `lfsr_enable` stays 0.
  - All other behaviour is identical.
- Undefined: no `bypass` port; every frame is scrambled.

## Structure
- Shared package `scrambler_pkg`:
  - LFSR register addresses `LFSR_ADDR_FIRST = 12'h0E8`, `LFSR_ADDR_LAST = 12'h0EE`.
  - State enum `scr_state_t` {IDLE, RUN, DRAIN}.
  - Defaults for `POLY_WIDTH` and `DATA_WIDTH`.
- One sub-module `scr_out_fifo2`: 2-entry FIFO, DATA_WIDTH+1 wide, with count, push/pop and simultaneous handling.

## Test plan
- Reset, `start` with `frame_len=4`, streaming words 0x0000_0001..0x0000_0004 with `out_ready=1`, `lfsr_state` from a live LFSR seeded 0x1 at word 0:
  - outputs equal data XOR the per-cycle low 32 state bits;
  - 4 `lfsr_enable` pulses;
  - `out_last` on word 4;
  - `done` one cycle.
- `out_ready=0`, 3 words offered: exactly 2 accepted, `in_ready=0`. Release `out_ready`: order preserved, third accepted after the first pop.
- `frame_len=0`: exactly one word accepted with `out_last=1`.
- Write to 0x0EA while busy → `seed_err=1` until the next `start`. Write to 0x0EF → no error.
- `rst` asserted with 2 words buffered → `out_valid=0`, `busy=0` next cycle, no further `lfsr_enable`.
- With `SCRAMBLER_BYPASS_EN`, `bypass=1`, data 0xDEAD_BEEF → output 0xDEAD_BEEF, `lfsr_enable` never high.

Source files
------------

// File: rtl/scrambler_pkg.sv
// Shared types and constants for the scrambler XOR stage.
// LFSR seed register window, FSM states and default widths.
package scrambler_pkg;

  localparam int POLY_WIDTH_DEF = 195;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 16;

  localparam logic [11:0] LFSR_ADDR_FIRST = 12'h0E8;
  localparam logic [11:0] LFSR_ADDR_LAST  = 12'h0EE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scr_state_t;

  function automatic logic is_seed_addr(
    input logic [11:0] a
  );
    return (a >= LFSR_ADDR_FIRST) &&
           (a <= LFSR_ADDR_LAST);
  endfunction

endpackage

// File: rtl/scrambler_xor_stage_if.sv
// Input/output stream bundle of the scrambler.
// master drives words in and takes them out; slave is the stage.
interface scrambler_xor_stage_if
  import scrambler_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/scr_out_fifo2.sv
// Two-entry output FIFO holding {last, data} words.
// Push and pop in one cycle keep the count and ordering.
module scr_out_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign head    = mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scrambler_xor_stage.sv
// XORs framed data words with an LFSR keystream slice.
// Optional SCRAMBLER_BYPASS_EN adds a per-frame bypass input.
module scrambler_xor_stage
  import scrambler_pkg::*;
#(
  parameter int POLY_WIDTH = POLY_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int KEY_LSB    = 0,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  write,
  input  logic [11:0]           addr,
  input  logic [POLY_WIDTH-1:0] lfsr_state,
  output logic                  lfsr_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  seed_err,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic                  bypass,
`endif
  scrambler_xor_stage_if.slave  strm
);

  scr_state_t           state;
  scr_state_t           state_nxt;
  logic [LEN_WIDTH-1:0] remaining;
  logic [1:0]           count;
  logic [DATA_WIDTH:0]  head;
  logic [DATA_WIDTH-1:0] key;
  logic                 accept;
  logic                 pop;
  logic                 last_word;
  logic                 fsm_done;
  logic                 unused_lfsr;

  assign unused_lfsr = ^lfsr_state;

`ifdef SCRAMBLER_BYPASS_EN
  logic bypass_q;

  // keystream is zero and the LFSR is left alone in bypass
  always_comb begin
    key         = bypass_q ? '0 :
                  lfsr_state[KEY_LSB +: DATA_WIDTH];
    lfsr_enable = accept & ~bypass_q;
  end

  // bypass choice held for the whole frame
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if (state == IDLE && start) begin
      bypass_q <= bypass;
    end
  end
`else
  // one LFSR step-group per accepted word
  always_comb begin
    key         = lfsr_state[KEY_LSB +: DATA_WIDTH];
    lfsr_enable = accept;
  end
`endif

  assign busy          = (state != IDLE);
  assign strm.in_ready = (state == RUN) &&
                         (count != 2'd2);
  assign accept        = strm.in_valid &
                         strm.in_ready & ~rst;
  assign strm.out_valid = (count != 2'd0);
  assign pop           = strm.out_valid &
                         strm.out_ready;
  assign strm.out_data = head[DATA_WIDTH-1:0];
  assign strm.out_last = head[DATA_WIDTH];
  assign last_word     =
    (remaining == LEN_WIDTH'(1));
  assign done          = fsm_done & ~rst;

  // next-state and frame completion pulse
  always_comb begin
    state_nxt = state;
    fsm_done  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start) state_nxt = RUN;
      end
      (state == RUN): begin
        if (accept && last_word)
          state_nxt = DRAIN;
      end
      default: begin
        if (pop && count == 2'd1) begin
          state_nxt = IDLE;
          fsm_done  = 1'b1;
        end
      end
    endcase
  end

  // state, word counter and sticky seed guard
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      seed_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        remaining <= (frame_len == '0) ?
                     LEN_WIDTH'(1) : frame_len;
        seed_err  <= 1'b0;
      end else begin
        if (accept)
          remaining <= remaining - LEN_WIDTH'(1);
        if (busy && write && is_seed_addr(addr))
          seed_err <= 1'b1;
      end
    end
  end

  scr_out_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ({last_word, strm.in_data ^ key}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_scrambler_xor_stage.sv
// Directed bench for scrambler_xor_stage with a toy LFSR.
// The toy LFSR shifts left by one per enable from seed 1.
module tb_scrambler_xor_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  frame_len = '0;
  logic         write = 1'b0;
  logic [11:0]  addr = '0;
  logic [194:0] lfsr = '0;
  logic         do_seed = 1'b0;
  logic         lfsr_enable;
  logic         busy;
  logic         done;
  logic         seed_err;
`ifdef SCRAMBLER_BYPASS_EN
  logic         bypass = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int eb;
  int db;
  int qb;
  logic [32:0] got_q [$];

  scrambler_xor_stage_if #(.DATA_WIDTH(32)) strm();

  always #5 clk = ~clk;

  scrambler_xor_stage dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_len   (frame_len),
    .write       (write),
    .addr        (addr),
    .lfsr_state  (lfsr),
    .lfsr_enable (lfsr_enable),
    .busy        (busy),
    .done        (done),
    .seed_err    (seed_err),
`ifdef SCRAMBLER_BYPASS_EN
    .bypass      (bypass),
`endif
    .strm        (strm)
  );

  always @(posedge clk) begin
    if (do_seed)
      lfsr <= 195'd1;
    else if (lfsr_enable)
      lfsr <= {lfsr[193:0], lfsr[194] ^ lfsr[187]};
  end

  always @(negedge clk) begin
    if (lfsr_enable) en_cnt++;
    if (done) done_cnt++;
    if (strm.out_valid && strm.out_ready)
      got_q.push_back({strm.out_last, strm.out_data});
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag,
                          input int i,
                          input logic [32:0] exp);
    logic [32:0] w;
    w = (got_q.size() > qb + i) ? got_q[qb + i] : 'x;
    check(tag, {31'd0, w}, {31'd0, exp});
  endtask

  task automatic mark();
    eb = en_cnt;
    db = done_cnt;
    qb = got_q.size();
  endtask

  task automatic seed_lfsr();
    do_seed = 1'b1;
    @(posedge clk); #1;
    do_seed = 1'b0;
  endtask

  task automatic begin_frame(input logic [15:0] len);
    frame_len = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    strm.in_valid = 1'b1;
    strm.in_data = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (strm.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    strm.in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && busy; n++) begin
      @(posedge clk); #1;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    strm.in_valid = 1'b0;
    strm.in_data = '0;
    strm.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en",   {63'd0, lfsr_enable}, 0);
    check("rst_ir",   {63'd0, strm.in_ready}, 0);
    check("rst_ov",   {63'd0, strm.out_valid}, 0);
    check("rst_od",   {32'd0, strm.out_data}, 0);
    check("rst_ol",   {63'd0, strm.out_last}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_done", {63'd0, done}, 0);
    check("rst_serr", {63'd0, seed_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 4-word frame streamed with out_ready high
    seed_lfsr();
    mark();
    strm.out_ready = 1'b1;
    begin_frame(16'd4);
    check("t1_busy", {63'd0, busy}, 1);
    send(32'h1);
    send(32'h2);
    send(32'h3);
    send(32'h4);
    wait_idle();
    check("t1_n", got_q.size() - qb, 4);
    chk_word("t1_w0", 0, {1'b0, 32'h0});
    chk_word("t1_w1", 1, {1'b0, 32'h0});
    chk_word("t1_w2", 2, {1'b0, 32'h7});
    chk_word("t1_w3", 3, {1'b1, 32'hC});
    check("t1_en", en_cnt - eb, 4);
    check("t1_done", done_cnt - db, 1);

    // back-pressure: only two words fit
    seed_lfsr();
    mark();
    strm.out_ready = 1'b0;
    begin_frame(16'd3);
    send(32'h10);
    send(32'h20);
    strm.in_valid = 1'b1;
    strm.in_data = 32'h30;
    repeat (3) @(posedge clk);
    #1;
    check("t2_full_ir", {63'd0, strm.in_ready}, 0);
    check("t2_full_en", en_cnt - eb, 2);
    strm.out_ready = 1'b1;
    check("t2_pop_ir", {63'd0, strm.in_ready}, 0);
    send(32'h30);
    wait_idle();
    check("t2_n", got_q.size() - qb, 3);
    chk_word("t2_w0", 0, {1'b0, 32'h11});
    chk_word("t2_w1", 1, {1'b0, 32'h22});
    chk_word("t2_w2", 2, {1'b1, 32'h34});
    check("t2_en", en_cnt - eb, 3);

    // zero length behaves as one word
    seed_lfsr();
    mark();
    begin_frame(16'd0);
    send(32'hA5);
    strm.in_valid = 1'b1;
    strm.in_data = 32'hFF;
    repeat (3) @(posedge clk);
    #1;
    strm.in_valid = 1'b0;
    wait_idle();
    check("t3_n", got_q.size() - qb, 1);
    chk_word("t3_w0", 0, {1'b1, 32'hA4});
    check("t3_en", en_cnt - eb, 1);

    // seed guard window
    seed_lfsr();
    begin_frame(16'd2);
    write = 1'b1;
    addr = 12'h0EF;
    @(posedge clk); #1;
    write = 1'b0;
    check("t4_ef", {63'd0, seed_err}, 0);
    write = 1'b1;
    addr = 12'h0EA;
    @(posedge clk); #1;
    write = 1'b0;
    check("t4_ea", {63'd0, seed_err}, 1);
    send(32'h1);
    send(32'h2);
    wait_idle();
    check("t4_sticky", {63'd0, seed_err}, 1);
    begin_frame(16'd1);
    check("t4_clr", {63'd0, seed_err}, 0);
    send(32'h3);
    wait_idle();

    // reset with two words buffered
    seed_lfsr();
    mark();
    strm.out_ready = 1'b0;
    begin_frame(16'd4);
    send(32'h1);
    send(32'h2);
    strm.in_valid = 1'b1;
    strm.in_data = 32'h3;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_en", {63'd0, lfsr_enable}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_ov", {63'd0, strm.out_valid}, 0);
    check("t5_busy", {63'd0, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    strm.in_valid = 1'b0;
    check("t5_en", en_cnt - eb, 2);
    check("t5_ir", {63'd0, strm.in_ready}, 0);

`ifdef SCRAMBLER_BYPASS_EN
    // bypass passes words untouched
    seed_lfsr();
    mark();
    strm.out_ready = 1'b1;
    bypass = 1'b1;
    begin_frame(16'd1);
    bypass = 1'b0;
    send(32'hDEAD_BEEF);
    wait_idle();
    chk_word("t6_w0", 0, {1'b1, 32'hDEAD_BEEF});
    check("t6_en", en_cnt - eb, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
